// File: rtl/red_pitaya_iq_demodulator_block_if.sv
// ============================================================================
// Module   : red_pitaya_iq_demodulator_block_if
// Brief    : Sample/LO inputs and I/Q result outputs of the IQ demodulator.
// Revision : 1.0
// ============================================================================
`default_nettype none

interface red_pitaya_iq_demodulator_block_if #(
    parameter int INBITS  = 14,
    parameter int SINBITS = 14,
    parameter int OUTBITS = 18,
    parameter int AVGBITS = 4
);
    logic signed [SINBITS-1:0] sin;
    logic signed [SINBITS-1:0] cos;
    logic signed [INBITS-1:0]  signal_i;
    logic        [AVGBITS-1:0] avg_log2_i;
    logic                      sync_i;
    logic signed [OUTBITS-1:0] signal_i_o;
    logic signed [OUTBITS-1:0] signal_q_o;
    logic                      valid_o;
    logic                      sat_o;

    modport master (
        output sin, cos, signal_i, avg_log2_i, sync_i,
        input  signal_i_o, signal_q_o, valid_o, sat_o
    );

    modport slave (
        input  sin, cos, signal_i, avg_log2_i, sync_i,
        output signal_i_o, signal_q_o, valid_o, sat_o
    );
endinterface

`default_nettype wire

// File: rtl/red_pitaya_iq_demodulator_block.sv
// ============================================================================
// Module   : red_pitaya_iq_demodulator_block
// Brief    : Mixes a sample stream with sin/cos LO, integrate-and-dump averages
//            over 2^avg_log2 samples, scales and saturates to I/Q outputs.
// Revision : 1.0
// ============================================================================
`default_nettype none

module red_pitaya_iq_demodulator_block #(
    parameter int INBITS    = 14,
    parameter int SINBITS   = 14,
    parameter int OUTBITS   = 18,
    parameter int SHIFTBITS = 0,
    parameter int AVGBITS   = 4
) (
    input  logic                              clk_i,
    input  logic                              rst_i,
    red_pitaya_iq_demodulator_block_if.slave  bus
);
    localparam int PRODBITS  = INBITS + SINBITS;
    localparam int CNTBITS   = (1 << AVGBITS) - 1;
    localparam int ACCBITS   = PRODBITS + CNTBITS;
    localparam int BASESHIFT = SINBITS - 1 - SHIFTBITS;

    localparam logic signed [ACCBITS-1:0] OUT_MAX =
        {{(ACCBITS-OUTBITS+1){1'b0}}, {(OUTBITS-1){1'b1}}};
    localparam logic signed [ACCBITS-1:0] OUT_MIN =
        {{(ACCBITS-OUTBITS+1){1'b1}}, {(OUTBITS-1){1'b0}}};

    // stage 1
    logic signed [INBITS-1:0]   sig_r;
    logic signed [SINBITS-1:0]  sin_r;
    logic signed [SINBITS-1:0]  cos_r;
    logic                       v1;
    // stage 2
    logic signed [PRODBITS-1:0] prod_i;
    logic signed [PRODBITS-1:0] prod_q;
    logic                       v2;
    // stage 3
    logic signed [ACCBITS-1:0]  acc_i;
    logic signed [ACCBITS-1:0]  acc_q;
    logic        [CNTBITS-1:0]  cnt;
    logic        [AVGBITS-1:0]  navg;
    logic signed [OUTBITS-1:0]  out_i;
    logic signed [OUTBITS-1:0]  out_q;
    logic                       valid;
    logic                       sat;

    logic signed [PRODBITS-1:0] sig_x;
    logic signed [PRODBITS-1:0] sin_x;
    logic signed [PRODBITS-1:0] cos_x;
    logic signed [PRODBITS-1:0] mul_i;
    logic signed [PRODBITS-1:0] mul_q;
    logic signed [ACCBITS-1:0]  sum_i;
    logic signed [ACCBITS-1:0]  sum_q;
    logic signed [ACCBITS-1:0]  shifted_i;
    logic signed [ACCBITS-1:0]  shifted_q;
    logic        [7:0]          shamt;
    logic        [CNTBITS-1:0]  last;
    logic        [OUTBITS:0]    res_i;
    logic        [OUTBITS:0]    res_q;

    // Returns {saturated_flag, clamped_value}.
    function automatic logic [OUTBITS:0] saturate(input logic signed [ACCBITS-1:0] x);
        logic [OUTBITS:0] r;
        if (x > OUT_MAX)
            r = {1'b1, OUT_MAX[OUTBITS-1:0]};
        else if (x < OUT_MIN)
            r = {1'b1, OUT_MIN[OUTBITS-1:0]};
        else
            r = {1'b0, x[OUTBITS-1:0]};
        return r;
    endfunction

    assign sig_x = PRODBITS'(sig_r);
    assign sin_x = PRODBITS'(sin_r);
    assign cos_x = PRODBITS'(cos_r);
    assign mul_i = sig_x * sin_x;
    assign mul_q = sig_x * cos_x;

    // Dump includes the current product, so the window needs no extra cycle.
    assign sum_i     = acc_i + {{CNTBITS{prod_i[PRODBITS-1]}}, prod_i};
    assign sum_q     = acc_q + {{CNTBITS{prod_q[PRODBITS-1]}}, prod_q};
    assign shamt     = 8'(navg) + 8'(BASESHIFT);
    assign shifted_i = sum_i >>> shamt;
    assign shifted_q = sum_q >>> shamt;
    assign res_i     = saturate(shifted_i);
    assign res_q     = saturate(shifted_q);
    assign last      = ~({CNTBITS{1'b1}} << navg);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            sig_r  <= '0;
            sin_r  <= '0;
            cos_r  <= '0;
            v1     <= 1'b0;
            prod_i <= '0;
            prod_q <= '0;
            v2     <= 1'b0;
            acc_i  <= '0;
            acc_q  <= '0;
            cnt    <= '0;
            navg   <= '0;
            out_i  <= '0;
            out_q  <= '0;
            valid  <= 1'b0;
            sat    <= 1'b0;
        end else begin
            sig_r  <= bus.signal_i;
            sin_r  <= bus.sin;
            cos_r  <= bus.cos;
            prod_i <= mul_i;
            prod_q <= mul_q;
            if (bus.sync_i) begin
                // Sync aborts the window; results on the outputs are kept.
                v1    <= 1'b0;
                v2    <= 1'b0;
                acc_i <= '0;
                acc_q <= '0;
                cnt   <= '0;
                navg  <= bus.avg_log2_i;
                valid <= 1'b0;
            end else begin
                v1 <= 1'b1;
                v2 <= v1;
                if (v2 && (cnt == last)) begin
                    out_i <= res_i[OUTBITS-1:0];
                    out_q <= res_q[OUTBITS-1:0];
                    sat   <= res_i[OUTBITS] | res_q[OUTBITS];
                    acc_i <= '0;
                    acc_q <= '0;
                    cnt   <= '0;
                    navg  <= bus.avg_log2_i;
                    valid <= 1'b1;
                end else if (v2) begin
                    acc_i <= sum_i;
                    acc_q <= sum_q;
                    cnt   <= cnt + CNTBITS'(1);
                    valid <= 1'b0;
                end else begin
                    valid <= 1'b0;
                end
            end
        end
    end

    assign bus.signal_i_o = out_i;
    assign bus.signal_q_o = out_q;
    assign bus.valid_o    = valid;
    assign bus.sat_o      = sat;

endmodule

`default_nettype wire

// File: tb/tb_red_pitaya_iq_demodulator_block.sv
// ============================================================================
// Module   : tb_red_pitaya_iq_demodulator_block
// Brief    : Directed self-checking bench for the IQ demodulator (SHIFTBITS 0 and 4).
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_red_pitaya_iq_demodulator_block;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_tests = 0;
    int   n_fail  = 0;

    always #5 clk = ~clk;

    red_pitaya_iq_demodulator_block_if #(.INBITS(14), .SINBITS(14), .OUTBITS(18), .AVGBITS(4)) bus0();
    red_pitaya_iq_demodulator_block_if #(.INBITS(14), .SINBITS(14), .OUTBITS(18), .AVGBITS(4)) bus4();

    red_pitaya_iq_demodulator_block #(
        .INBITS(14), .SINBITS(14), .OUTBITS(18), .SHIFTBITS(0), .AVGBITS(4)
    ) dut0 (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus0)
    );

    red_pitaya_iq_demodulator_block #(
        .INBITS(14), .SINBITS(14), .OUTBITS(18), .SHIFTBITS(4), .AVGBITS(4)
    ) dut4 (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus4)
    );

    task automatic check_value(input string tag, input logic signed [63:0] got,
                               input logic signed [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check0(input string tag, input int ei, input int eq,
                          input int ev, input int es);
        check_value({tag, " I"},     bus0.signal_i_o, ei);
        check_value({tag, " Q"},     bus0.signal_q_o, eq);
        check_value({tag, " valid"}, bus0.valid_o,    ev);
        check_value({tag, " sat"},   bus0.sat_o,      es);
    endtask

    // One sync edge: clears the pipeline and latches the new window length.
    task automatic restart(input int avg, input int sig, input int s, input int c);
        bus0.avg_log2_i = 4'(avg);
        bus0.signal_i   = 14'(sig);
        bus0.sin        = 14'(s);
        bus0.cos        = 14'(c);
        bus0.sync_i     = 1'b1;
        tick();
        bus0.sync_i     = 1'b0;
    endtask

    initial begin
        bus4.signal_i   = -14'sd8192;
        bus4.sin        = -14'sd8192;
        bus4.cos        = 14'sd0;
        bus4.avg_log2_i = 4'd0;
        bus4.sync_i     = 1'b0;

        // Reset with random stimulus: outputs stay at zero.
        for (int k = 0; k < 4; k++) begin
            bus0.signal_i   = 14'($urandom);
            bus0.sin        = 14'($urandom);
            bus0.cos        = 14'($urandom);
            bus0.avg_log2_i = 4'($urandom);
            bus0.sync_i     = 1'($urandom);
            tick();
            check0("reset", 0, 0, 0, 0);
        end

        // avg=0: one result per sample, first one after the third edge.
        bus0.signal_i   = 14'sd4000;
        bus0.sin        = 14'sd8191;
        bus0.cos        = 14'sd0;
        bus0.avg_log2_i = 4'd0;
        bus0.sync_i     = 1'b0;
        rst = 1'b0;
        tick();
        check_value("avg0 e1 valid", bus0.valid_o, 0);
        tick();
        check_value("avg0 e2 valid", bus0.valid_o, 0);
        for (int k = 3; k <= 6; k++) begin
            tick();
            check0("avg0 stream", 3999, 0, 1, 0);
            if (k == 3) begin
                check_value("shift4 clamp I",   bus4.signal_i_o, 131071);
                check_value("shift4 clamp sat", bus4.sat_o,      1);
                check_value("shift4 valid",     bus4.valid_o,    1);
                check_value("shift4 Q",         bus4.signal_q_o, 0);
            end
        end

        // SHIFTBITS=4, in range: -8192*8191 >>> 9 = -131056, no saturation.
        bus4.sin = 14'sd8191;
        tick(); tick(); tick();
        check_value("shift4 inrange I",   bus4.signal_i_o, -131056);
        check_value("shift4 inrange sat", bus4.sat_o,      0);

        // avg=2: 4-sample average, strobe one cycle in four.
        restart(2, 1000, 8191, -8192);
        for (int k = 1; k <= 10; k++) begin
            tick();
            if (k == 6 || k == 10)
                check0("avg2 dump", 999, -1000, 1, 0);
            else
                check_value("avg2 no strobe", bus0.valid_o, 0);
            if (k == 8)
                check_value("avg2 hold I", bus0.signal_i_o, 999);
        end

        // avg=3, sync after 5 samples: aborted window never dumps.
        restart(3, 2000, 8191, 8191);
        for (int k = 1; k <= 5; k++) tick();
        bus0.signal_i = -14'sd1000;
        bus0.cos      = -14'sd8192;
        bus0.sync_i   = 1'b1;
        tick();
        bus0.sync_i   = 1'b0;
        for (int k = 1; k <= 9; k++) begin
            tick();
            check_value("sync no strobe", bus0.valid_o, 0);
            if (k == 5)
                check_value("sync hold I", bus0.signal_i_o, 999);
        end
        tick();
        check0("sync new window", -1000, 1000, 1, 0);

        // avg 3 -> 0 mid-window: current window still takes 8 samples.
        restart(3, 1000, 8191, -8192);
        for (int k = 1; k <= 12; k++) begin
            if (k == 3) bus0.avg_log2_i = 4'd0;
            tick();
            if (k < 10)
                check_value("avgchg no strobe", bus0.valid_o, 0);
            else if (k == 10)
                check0("avgchg full window", 999, -1000, 1, 0);
            else
                check0("avgchg per-sample", 999, -1000, 1, 0);
        end

        // Asynchronous reset takes effect without a clock edge.
        @(negedge clk);
        rst = 1'b1;
        #1;
        check0("async reset", 0, 0, 0, 0);
        check_value("async reset shift4 I", bus4.signal_i_o, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
